// File: rtl/daq_rx_rate_sel_fsm.sv
// daq_rx_rate_sel_fsm
// Receive-side rate-select sequencer for the optical DAQ GTX link. It switches
// the receiver between 3.2 Gbps and 1.25 Gbps, runs the CDR and PCS reset
// pulses, waits for byte alignment and reports the locked rate. Timeouts while
// waiting for the rate change or for alignment go through a one-cycle RETRY
// state that bumps a saturating retry counter.
//
// Build option: define DAQ_RX_ALIGN_FILTER_EN to debounce alignment. Lock then
// needs 16 consecutive good samples and unlock needs 4 consecutive lost
// samples. Without the macro both decisions act on a single sample.
//
// Every output is registered from the next-state decode, so it changes on the
// same edge as the state register it describes.
module daq_rx_rate_sel_fsm #(
    parameter int RST_CYC   = 4,
    parameter int RATE_TMO  = 1023,
    parameter int ALIGN_TMO = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DAQ_RATE,
    input  logic       RXRATEDONE,
    input  logic       RXRESETDONE,
    input  logic       RXBYTEISALIGNED,
    output logic [1:0] RXRATE,
    output logic       RX_CLK_SEL,
    output logic       RXCDRRESET,
    output logic       RXPCSRESET,
    output logic       RX_RATE_3_2,
    output logic       RX_RATE_1_25,
    output logic       RX_LINK_UP,
    output logic [3:0] RETRY_CNT,
    output logic [3:0] DQRX_STATE
);

    typedef enum logic [3:0] {
        INIT        = 4'b0000,
        LOCKED_3_2  = 4'b0001,
        LOCKED_1_25 = 4'b0010,
        SET_RATE    = 4'b0011,
        CDR_RST     = 4'b0100,
        PCS_RST     = 4'b0101,
        WAIT_ALIGN  = 4'b0110,
        RETRY       = 4'b0111
    } state_t;

    // Timer values on the last cycle of each bounded wait.
    localparam logic [15:0] RST_LAST   = 16'(RST_CYC - 1);
    localparam logic [15:0] RATE_LAST  = 16'(RATE_TMO);
    localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_TMO);

    state_t      state;
    state_t      next_state;
    logic        target;
    logic        next_target;
    logic [15:0] timer;
    logic        state_chg;
    logic        align_ok;
    logic        align_lost;

    // Retry counter increments but sticks at its maximum.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign state_chg  = (next_state != state);
    assign DQRX_STATE = state;

`ifdef DAQ_RX_ALIGN_FILTER_EN
    logic [3:0] good_cnt;
    logic [1:0] loss_cnt;

    // good_cnt holds the number of earlier consecutive good samples, so the
    // current good sample is the 16th when it reads 15; same idea for loss.
    assign align_ok   = RXRESETDONE && RXBYTEISALIGNED && (good_cnt == 4'd15);
    assign align_lost = !RXBYTEISALIGNED && (loss_cnt == 2'd3);

    // Run-length counters for the alignment debounce, restarted on any state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            good_cnt <= '0;
            loss_cnt <= '0;
        end else if (state_chg) begin
            good_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            if (state == WAIT_ALIGN && RXRESETDONE && RXBYTEISALIGNED)
                good_cnt <= good_cnt + 4'd1;
            else
                good_cnt <= '0;

            if ((state == LOCKED_3_2 || state == LOCKED_1_25) && !RXBYTEISALIGNED)
                loss_cnt <= loss_cnt + 2'd1;
            else
                loss_cnt <= '0;
        end
    end
`else
    assign align_ok   = RXRESETDONE && RXBYTEISALIGNED;
    assign align_lost = !RXBYTEISALIGNED;
`endif

    // Next-state and target selection.
    always_comb begin
        next_state  = state;
        next_target = target;
        case (state)
            INIT: begin
                next_target = DAQ_RATE;
                next_state  = CDR_RST;
            end
            LOCKED_3_2: begin
                // A rate request takes priority over loss of alignment.
                next_target = DAQ_RATE;
                if (!DAQ_RATE)
                    next_state = SET_RATE;
                else if (align_lost)
                    next_state = CDR_RST;
            end
            LOCKED_1_25: begin
                next_target = DAQ_RATE;
                if (DAQ_RATE)
                    next_state = SET_RATE;
                else if (align_lost)
                    next_state = CDR_RST;
            end
            SET_RATE: begin
                if (RXRATEDONE)
                    next_state = CDR_RST;
                else if (timer == RATE_LAST)
                    next_state = RETRY;
            end
            CDR_RST: begin
                if (timer == RST_LAST)
                    next_state = PCS_RST;
            end
            PCS_RST: begin
                if (timer == RST_LAST)
                    next_state = WAIT_ALIGN;
            end
            WAIT_ALIGN: begin
                if (align_ok)
                    next_state = target ? LOCKED_3_2 : LOCKED_1_25;
                else if (timer == ALIGN_LAST)
                    next_state = RETRY;
            end
            RETRY: begin
                next_state = SET_RATE;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // State, target and dwell timer; the timer restarts on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= INIT;
            target <= 1'b1;
            timer  <= '0;
        end else begin
            state  <= next_state;
            target <= next_target;
            timer  <= state_chg ? 16'd0 : timer + 16'd1;
        end
    end

    // Registered outputs decoded from the next state and next target.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RXRATE       <= 2'b11;
            RX_CLK_SEL   <= 1'b1;
            RXCDRRESET   <= 1'b0;
            RXPCSRESET   <= 1'b0;
            RX_RATE_3_2  <= 1'b0;
            RX_RATE_1_25 <= 1'b0;
            RX_LINK_UP   <= 1'b0;
            RETRY_CNT    <= '0;
        end else begin
            RXRATE       <= next_target ? 2'b11 : 2'b10;
            RX_CLK_SEL   <= next_target;
            RXCDRRESET   <= (next_state == CDR_RST);
            RXPCSRESET   <= (next_state == PCS_RST);
            RX_RATE_3_2  <= (next_state == LOCKED_3_2);
            RX_RATE_1_25 <= (next_state == LOCKED_1_25);
            RX_LINK_UP   <= (next_state == LOCKED_3_2) || (next_state == LOCKED_1_25);
            if (next_state == RETRY)
                RETRY_CNT <= sat_inc4(RETRY_CNT);
        end
    end

endmodule

// File: tb/tb_daq_rx_rate_sel_fsm.sv
// Bench for daq_rx_rate_sel_fsm: directed scenarios followed by random stimulus,
// with every output compared each falling edge against a phase/duration model.
module tb_daq_rx_rate_sel_fsm;

    localparam int RST_CYC   = 4;
    localparam int RATE_TMO  = 1023;
    localparam int ALIGN_TMO = 65535;
`ifdef DAQ_RX_ALIGN_FILTER_EN
    localparam int LOCK_RUN = 16;
    localparam int LOSS_RUN = 4;
`else
    localparam int LOCK_RUN = 1;
    localparam int LOSS_RUN = 1;
`endif

    localparam logic [3:0] S_INIT  = 4'd0;
    localparam logic [3:0] S_L32   = 4'd1;
    localparam logic [3:0] S_L125  = 4'd2;
    localparam logic [3:0] S_SET   = 4'd3;
    localparam logic [3:0] S_CDR   = 4'd4;
    localparam logic [3:0] S_PCS   = 4'd5;
    localparam logic [3:0] S_WAIT  = 4'd6;
    localparam logic [3:0] S_RETRY = 4'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       daq_rate = 1'b1;
    logic       rxratedone = 1'b0;
    logic       rxresetdone = 1'b1;
    logic       rxbyteisaligned = 1'b1;
    logic [1:0] rxrate;
    logic       rx_clk_sel, rxcdrreset, rxpcsreset;
    logic       rx_rate_3_2, rx_rate_1_25, rx_link_up;
    logic [3:0] retry_cnt, dqrx_state;

    int tests = 0;
    int fails = 0;

    daq_rx_rate_sel_fsm #(
        .RST_CYC  (RST_CYC),
        .RATE_TMO (RATE_TMO),
        .ALIGN_TMO(ALIGN_TMO)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .DAQ_RATE       (daq_rate),
        .RXRATEDONE     (rxratedone),
        .RXRESETDONE    (rxresetdone),
        .RXBYTEISALIGNED(rxbyteisaligned),
        .RXRATE         (rxrate),
        .RX_CLK_SEL     (rx_clk_sel),
        .RXCDRRESET     (rxcdrreset),
        .RXPCSRESET     (rxpcsreset),
        .RX_RATE_3_2    (rx_rate_3_2),
        .RX_RATE_1_25   (rx_rate_1_25),
        .RX_LINK_UP     (rx_link_up),
        .RETRY_CNT      (retry_cnt),
        .DQRX_STATE     (dqrx_state)
    );

    always #5 clk = ~clk;

    // Model: which phase the link is in, how many cycles it has spent there
    // (counting the current one), the alignment run lengths and retry count.
    typedef struct packed {
        logic [3:0] st;
        logic       tgt;
        int         in_ph;
        int         good;
        int         bad;
        int         retry;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t c, input logic dr, input logic rd,
                                          input logic rsd, input logic al);
        model_t n;
        int good;
        int bad;
        n    = c;
        good = (c.st == S_WAIT && rsd && al) ? c.good + 1 : 0;
        bad  = ((c.st == S_L32 || c.st == S_L125) && !al) ? c.bad + 1 : 0;
        case (c.st)
            S_INIT: begin
                n.tgt = dr;
                n.st  = S_CDR;
            end
            S_L32, S_L125: begin
                n.tgt = dr;
                if (dr != (c.st == S_L32)) n.st = S_SET;
                else if (bad >= LOSS_RUN)  n.st = S_CDR;
            end
            S_SET: begin
                if (rd)                              n.st = S_CDR;
                else if (c.in_ph == RATE_TMO + 1)    n.st = S_RETRY;
            end
            S_CDR:   if (c.in_ph == RST_CYC) n.st = S_PCS;
            S_PCS:   if (c.in_ph == RST_CYC) n.st = S_WAIT;
            S_WAIT: begin
                if (good >= LOCK_RUN)                n.st = c.tgt ? S_L32 : S_L125;
                else if (c.in_ph == ALIGN_TMO + 1)   n.st = S_RETRY;
            end
            S_RETRY: n.st = S_SET;
            default: n.st = S_INIT;
        endcase
        if (n.st == S_RETRY) n.retry = (c.retry < 15) ? c.retry + 1 : 15;
        if (n.st != c.st) begin
            n.in_ph = 1;
            n.good  = 0;
            n.bad   = 0;
        end else begin
            n.in_ph = c.in_ph + 1;
            n.good  = good;
            n.bad   = bad;
        end
        return n;
    endfunction

    // Advance the model on each rising edge; reset it asynchronously.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.st    <= S_INIT;
            m.tgt   <= 1'b1;
            m.in_ph <= 1;
            m.good  <= 0;
            m.bad   <= 0;
            m.retry <= 0;
        end else begin
            m <= model_next(m, daq_rate, rxratedone, rxresetdone, rxbyteisaligned);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string name);
        int n;
        n = 0;
        while (dqrx_state !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(dqrx_state), 32'(code));
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("m_state",   32'(dqrx_state),   32'(m.st));
        chk("m_rxrate",  32'(rxrate),       m.tgt ? 32'd3 : 32'd2);
        chk("m_clk_sel", 32'(rx_clk_sel),   32'(m.tgt));
        chk("m_cdr",     32'(rxcdrreset),   32'(m.st == S_CDR));
        chk("m_pcs",     32'(rxpcsreset),   32'(m.st == S_PCS));
        chk("m_r32",     32'(rx_rate_3_2),  32'(m.st == S_L32));
        chk("m_r125",    32'(rx_rate_1_25), 32'(m.st == S_L125));
        chk("m_up",      32'(rx_link_up),   32'(m.st == S_L32 || m.st == S_L125));
        chk("m_retry",   32'(retry_cnt),    32'(m.retry));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cdr;
        int n_pcs;
        int n_set;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_state",   32'(dqrx_state), 0);
        chk("rst_rxrate",  32'(rxrate), 3);
        chk("rst_clk_sel", 32'(rx_clk_sel), 1);
        chk("rst_up",      32'(rx_link_up), 0);
        chk("rst_retry",   32'(retry_cnt), 0);

        // Bring-up at 3.2 Gbps: 4 cycles CDR reset, 4 cycles PCS reset, then lock.
        rst   = 1'b0;
        n_cdr = 0;
        n_pcs = 0;
        for (int i = 0; i < 2 * RST_CYC + 1 + LOCK_RUN; i++) begin
            @(negedge clk);
            if (rxcdrreset === 1'b1) n_cdr++;
            if (rxpcsreset === 1'b1) n_pcs++;
        end
        chk("cdr_pulse_len", n_cdr, 4);
        chk("pcs_pulse_len", n_pcs, 4);
        chk("lock32_state",  32'(dqrx_state), 1);
        chk("lock32_up",     32'(rx_link_up), 1);
        chk("lock32_flag",   32'(rx_rate_3_2), 1);
        chk("lock32_rxrate", 32'(rxrate), 3);
        chk("lock32_clksel", 32'(rx_clk_sel), 1);

        // Rate change to 1.25 with RXRATEDONE withheld: timeout after 1024 cycles.
        daq_rate   = 1'b0;
        rxratedone = 1'b0;
        @(negedge clk);
        chk("set_state",   32'(dqrx_state), 3);
        chk("set_rxrate",  32'(rxrate), 2);
        chk("set_clk_sel", 32'(rx_clk_sel), 0);
        n_set = 1;
        while (dqrx_state === S_SET && n_set < 1100) begin
            @(negedge clk);
            if (dqrx_state === S_SET) n_set++;
        end
        chk("set_dwell",   n_set, 1024);
        chk("retry_state", 32'(dqrx_state), 7);
        chk("retry_cnt_1", 32'(retry_cnt), 1);
        for (int r = 2; r <= 20; r++) begin
            wait_state(S_SET, 4, "retry_to_set");
            wait_state(S_RETRY, 1100, "set_timeout");
        end
        chk("retry_cnt_sat", 32'(retry_cnt), 15);

        // RXRATEDONE after 20 cycles in SET_RATE, then lock at 1.25.
        wait_state(S_SET, 4, "retry_to_set");
        repeat (20) @(negedge clk);
        rxratedone = 1'b1;
        @(negedge clk);
        rxratedone = 1'b0;
        wait_state(S_L125, 60 + LOCK_RUN, "relock_125");
        chk("lock125_flag",   32'(rx_rate_1_25), 1);
        chk("lock125_r32",    32'(rx_rate_3_2), 0);
        chk("lock125_rxrate", 32'(rxrate), 2);
        chk("lock125_clksel", 32'(rx_clk_sel), 0);

        // Alignment lost for one cycle.
        rxbyteisaligned = 1'b0;
        @(negedge clk);
        rxbyteisaligned = 1'b1;
`ifdef DAQ_RX_ALIGN_FILTER_EN
        chk("glitch_ignored", 32'(dqrx_state), 2);
        @(negedge clk);
        rxbyteisaligned = 1'b0;
        repeat (LOSS_RUN - 1) @(negedge clk);
        chk("loss_short", 32'(dqrx_state), 2);
        @(negedge clk);
        rxbyteisaligned = 1'b1;
`endif
        chk("loss_state",  32'(dqrx_state), 4);
        chk("loss_rxrate", 32'(rxrate), 2);
        chk("loss_clksel", 32'(rx_clk_sel), 0);

        // DAQ_RATE flips during PCS reset: lock at the old rate, then re-target.
        wait_state(S_PCS, 10, "reach_pcs");
        daq_rate = 1'b1;
        wait_state(S_L125, 20 + LOCK_RUN, "old_target_lock");
        @(negedge clk);
        chk("retarget_state",  32'(dqrx_state), 3);
        chk("retarget_rxrate", 32'(rxrate), 3);
        chk("retarget_clksel", 32'(rx_clk_sel), 1);
        repeat ($urandom_range(1, 30)) @(negedge clk);
        rxratedone = 1'b1;
        @(negedge clk);
        rxratedone = 1'b0;
        wait_state(S_L32, 40 + LOCK_RUN, "relock_32");

        // Asynchronous reset in the middle of the CDR reset pulse.
        rxbyteisaligned = 1'b0;
        wait_state(S_CDR, 10, "loss_for_reset");
        rxbyteisaligned = 1'b1;
        chk("pre_rst_cdr", 32'(rxcdrreset), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_cdr",    32'(rxcdrreset), 0);
        chk("async_state",  32'(dqrx_state), 0);
        chk("async_retry",  32'(retry_cnt), 0);
        chk("async_rxrate", 32'(rxrate), 3);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, checked by the per-cycle compare.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) daq_rate = ~daq_rate;
            rxratedone      = ($urandom_range(0, 39) == 0);
            rxresetdone     = ($urandom_range(0, 19) != 0);
            rxbyteisaligned = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/daq_rx_rate_sel_fsm.md
Name: daq_rx_rate_sel_fsm

Overview:
- Receive-side counterpart of the DAQ transmit rate-select FSM.
- Switches the optical DAQ GTX receiver between 3.2 Gbps and 1.25 Gbps. Drives RXRATE and the RX reference-clock select, sequences the CDR and PCS resets, and waits for byte alignment.
- Declares the link up at the selected rate. Retries on timeout.
- Sits between the DAQ rate control register and the GTX RX ports.

Parameters:
- RST_CYC, 4: cycles RXCDRRESET and RXPCSRESET are each held high.
- RATE_TMO, 1023: max cycles in SET_RATE waiting for RXRATEDONE.
- ALIGN_TMO, 65535: max cycles in WAIT_ALIGN.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- DAQ_RATE  in  1  requested rate: 1 = 3.2 Gbps, 0 = 1.25 Gbps.
- RXRATEDONE  in  1  GTX rate-change complete pulse.
- RXRESETDONE  in  1  GTX RX reset complete (level).
- RXBYTEISALIGNED  in  1  comma alignment achieved (level).
- RXRATE  out  2  GTX RX rate code: 2'b11 = 3.2, 2'b10 = 1.25.
- RX_CLK_SEL  out  1  RX refclk select: 1 = 160 MHz, 0 = 125 MHz.
- RXCDRRESET  out  1  CDR reset.
- RXPCSRESET  out  1  PCS reset.
- RX_RATE_3_2  out  1  locked at 3.2 Gbps.
- RX_RATE_1_25  out  1  locked at 1.25 Gbps.
- RX_LINK_UP  out  1  link locked at either rate.
- RETRY_CNT  out  4  saturating timeout-retry count.
- DQRX_STATE  out  4  current state code.

Behaviour:
- All outputs are registered and decoded from nextstate, so each output is valid in the same cycle the state register takes that value.
- DQRX_STATE equals the state register directly.
- Reset values:
  - state = INIT, target = 1.
  - RXRATE = 2'b11, RX_CLK_SEL = 1.
  - All other outputs = 0, RETRY_CNT = 0.
- Internal target bit: latched from DAQ_RATE only in INIT, LOCKED_3_2 and LOCKED_1_25. DAQ_RATE changes in any other state are ignored until a LOCKED state is reached.
- RXRATE = target ? 2'b11 : 2'b10 and RX_CLK_SEL = target, in every non-reset state.
- Timer: 16-bit, cleared on every state change, incremented otherwise.
- States and transitions:
  - INIT (0000): latch target; go to CDR_RST next cycle.
  - LOCKED_3_2 (0001): RX_RATE_3_2 = 1, RX_LINK_UP = 1.
    - If DAQ_RATE == 0: target <= 0, go to SET_RATE.
    - Else if RXBYTEISALIGNED == 0: go to CDR_RST, same target.
    - A rate change wins over loss of alignment.
  - LOCKED_1_25 (0010): RX_RATE_1_25 = 1, RX_LINK_UP = 1. Mirror of LOCKED_3_2 with DAQ_RATE == 1 triggering target <= 1.
  - SET_RATE (0011):
    - RXRATEDONE: go to CDR_RST.
    - Else timer == RATE_TMO: go to RETRY.
  - CDR_RST (0100): RXCDRRESET = 1. When timer == RST_CYC-1, go to PCS_RST. The reset pulse is exactly RST_CYC cycles.
  - PCS_RST (0101): RXPCSRESET = 1. When timer == RST_CYC-1, go to WAIT_ALIGN.
  - WAIT_ALIGN (0110):
    - RXRESETDONE && RXBYTEISALIGNED: go to LOCKED_3_2 if target, else LOCKED_1_25.
    - Else timer == ALIGN_TMO: go to RETRY.
  - RETRY (0111): one cycle. RETRY_CNT increments, saturating at 15. Go to SET_RATE.
  - Codes 1000–1111: go to INIT.
- RETRY_CNT clears only on RST.
- RST asserted mid-sequence: everything returns to reset values immediately. RXCDRRESET/RXPCSRESET drop asynchronously.

Optional Feature:
- Macro: DAQ_RX_ALIGN_FILTER_EN.
- When defined:
  - WAIT_ALIGN requires RXRESETDONE && RXBYTEISALIGNED high for 16 consecutive cycles before entering LOCKED. Any low sample restarts the count.
  - In LOCKED states, RXBYTEISALIGNED must be low for 4 consecutive cycles before going to CDR_RST.
  - Filter counters clear on state change.
- When not defined: both checks act on a single sample, as described above.

Test Plan:
- Reset release with DAQ_RATE = 1; RXRESETDONE = 1 and RXBYTEISALIGNED = 1 from cycle 10 -> CDR_RST for 4 cycles, PCS_RST for 4 cycles, then RX_LINK_UP = 1, RX_RATE_3_2 = 1, RXRATE = 11, RX_CLK_SEL = 1.
- From LOCKED_3_2, DAQ_RATE -> 0; RXRATEDONE after 20 cycles -> SET_RATE with RXRATE = 10 and RX_CLK_SEL = 0, then CDR_RST, PCS_RST, then LOCKED_1_25 with RX_RATE_1_25 = 1.
- RXRATEDONE never asserted -> RETRY entered after 1024 cycles in SET_RATE, RETRY_CNT = 1; repeating 20 times -> RETRY_CNT = 15 (saturated).
- In LOCKED_1_25, RXBYTEISALIGNED drops for 1 cycle -> CDR_RST entered, target still 0, RXRATE stays 10 (with the macro defined: no relock unless low for 4 cycles).
- DAQ_RATE toggles during PCS_RST -> completes to LOCKED for the old target, then next cycle enters SET_RATE toward the new target.
- RST pulsed during CDR_RST -> RXCDRRESET = 0 immediately, DQRX_STATE = 0000, RETRY_CNT = 0.
